univ_shift_reg: RTL



---
 rtl/univ_shift_reg.sv | 34 +++
 1 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift/storage register (hold, shift right, shift left, load)
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [1:0]       s,
  input  logic             dsr,
  input  logic             dsl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] n_q,
  output logic             sro,
  output logic             slo
);
  logic [WIDTH-1:0] nxt;
  // next-state select; an unknown mode propagates X into q
  always_comb begin
    nxt = s == 2'b11 ? d :
          s == 2'b10 ? {dsl, q[WIDTH-1:1]} :
          s == 2'b01 ? {q[WIDTH-2:0], dsr} :
          s == 2'b00 ? q : {WIDTH{1'bx}};
  end
  // register bank with asynchronous clear and clock enable
  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= RESET_VAL;
    else if (ce) q <= nxt;
  end
  assign n_q = ~q;
  assign sro = q[WIDTH-1];
  assign slo = q[0];
endmodule
